// File: rtl/mem_issue_queue_pkg.sv
// Shared defines for the memory issue path: renamed-op layout and physical
// register file geometry used by the issue queue and its wakeup logic.
package mem_issue_queue_pkg;

    localparam int RENAMED_OP_SZ  = 32;
    localparam int PR_ADDR_W      = 6;
    localparam int PHYS_REGS      = 64;
    localparam int SRC_A_LSB      = 8;
    localparam int SRC_B_LSB      = 14;
    localparam int HARDWIRED_REGS = 2;

endpackage

// File: rtl/mem_issue_queue_wakeup.sv
// Per-operand wakeup: a source is ready when it names a hardwired register
// or when its completion flag is raised this cycle.
module operand_wakeup
    import mem_issue_queue_pkg::*;
(
    input  logic [PR_ADDR_W-1:0] src_i,
    input  logic [PHYS_REGS-1:0] done_flags_i,
    output logic                 wake_o
);

    logic                 hardwired;
    logic [PR_ADDR_W-1:0] flag_idx;

    assign hardwired = (src_i < PR_ADDR_W'(HARDWIRED_REGS));
    // done_flags bit i reports register i+2; index wraps harmlessly for regs 0/1.
    assign flag_idx  = src_i - PR_ADDR_W'(HARDWIRED_REGS);
    assign wake_o    = hardwired | done_flags_i[flag_idx];

endmodule

// File: rtl/mem_issue_queue.sv
// In-order issue queue for renamed memory ops: the head entry issues once
// both of its sources are ready; younger entries wait behind it.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = RENAMED_OP_SZ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic [1:0]                    din_src_ready,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [PHYS_REGS-1:0]          done_flags,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      rdy_a_q, rdy_a_d;
    logic [DEPTH-1:0]      rdy_b_q, rdy_b_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [DEPTH-1:0]      occupied;
    logic [DEPTH-1:0]      wake_a, wake_b;
    logic                  enq_wake_a, enq_wake_b;
    logic                  do_push, do_pop;

    // Both sides use valid/ready: a transfer happens on a cycle where valid
    // and ready are both high; ready never depends on the other side's ready.
    assign din_ready  = (count_q < CNT_W'(DEPTH));
    assign dout_valid = (count_q != '0) & rdy_a_q[head_q] & rdy_b_q[head_q];
    assign dout       = data_q[head_q];
    assign count      = count_q;

    assign do_push = din_valid & din_ready;
    assign do_pop  = dout_valid & dout_ready;

    operand_wakeup u_enq_wake_a (
        .src_i        (din[SRC_A_LSB +: PR_ADDR_W]),
        .done_flags_i (done_flags),
        .wake_o       (enq_wake_a)
    );

    operand_wakeup u_enq_wake_b (
        .src_i        (din[SRC_B_LSB +: PR_ADDR_W]),
        .done_flags_i (done_flags),
        .wake_o       (enq_wake_b)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        operand_wakeup u_wake_a (
            .src_i        (data_q[i][SRC_A_LSB +: PR_ADDR_W]),
            .done_flags_i (done_flags),
            .wake_o       (wake_a[i])
        );

        operand_wakeup u_wake_b (
            .src_i        (data_q[i][SRC_B_LSB +: PR_ADDR_W]),
            .done_flags_i (done_flags),
            .wake_o       (wake_b[i])
        );
    end

    // An entry is resident when its distance from head is below count.
    always_comb begin
        logic [PTR_W-1:0] rel;
        rel      = '0;
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel         = PTR_W'(i) - head_q;
            occupied[i] = ({1'b0, rel} < count_q);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rdy_a_d = rdy_a_q;
        rdy_b_d = rdy_b_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            rdy_a_d = '0;
            rdy_b_d = '0;
        end else begin
            rdy_a_d = rdy_a_q | (occupied & wake_a);
            rdy_b_d = rdy_b_q | (occupied & wake_b);
            if (do_push) begin
                tail_d          = tail_q + PTR_W'(1);
                rdy_a_d[tail_q] = din_src_ready[0] | enq_wake_a;
                rdy_b_d[tail_q] = din_src_ready[1] | enq_wake_b;
            end
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdy_a_q <= '0;
            rdy_b_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rdy_a_q <= rdy_a_d;
            rdy_b_q <= rdy_b_d;
        end
    end

    // Payload needs no reset: it is only observed through occupied entries.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            data_q[tail_q] <= din;
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: each step drives inputs, advances one
// clock and checks outputs with immediate assertions.
module tb_mem_issue_queue;
    import mem_issue_queue_pkg::*;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [RENAMED_OP_SZ-1:0] din;
    logic [1:0]               din_src_ready;
    logic                     din_valid;
    logic                     din_ready;
    logic [PHYS_REGS-1:0]     done_flags;
    logic [RENAMED_OP_SZ-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [3:0]               count;

    int vectors;
    int miscompares;
    logic [RENAMED_OP_SZ-1:0] exp_q[$];
    logic [RENAMED_OP_SZ-1:0] exp_op;

    mem_issue_queue #(.DEPTH(8), .DATA_WIDTH(RENAMED_OP_SZ)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .din           (din),
        .din_src_ready (din_src_ready),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .done_flags    (done_flags),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_op(input int tag, input int a, input int b);
        logic [31:0] op;
        op = '0;
        op[31:20] = tag[11:0];
        op[SRC_A_LSB +: PR_ADDR_W] = a[PR_ADDR_W-1:0];
        op[SRC_B_LSB +: PR_ADDR_W] = b[PR_ADDR_W-1:0];
        return op;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        flush         = 1'b0;
        din           = '0;
        din_src_ready = 2'b00;
        din_valid     = 1'b0;
        done_flags    = '0;
        dout_ready    = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        check("reset_count", 32'(count), 0);
        check("reset_dout_valid", 32'(dout_valid), 0);
        check("reset_din_ready", 32'(din_ready), 1);

        // Wakeup latency: srcA=5 pending, srcB=0 hardwired.
        din = mk_op(1, 5, 0); din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("wk_count", 32'(count), 1);
        check("wk_not_ready0", 32'(dout_valid), 0);
        step();
        check("wk_not_ready1", 32'(dout_valid), 0);
        done_flags[3] = 1'b1;
        #1;
        check("wk_same_cycle", 32'(dout_valid), 0);
        step();
        done_flags = '0;
        check("wk_next_cycle", 32'(dout_valid), 1);
        check("wk_dout", dout, mk_op(1, 5, 0));
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check("wk_drained", 32'(count), 0);

        // Fill to capacity, refuse a ninth op, then pop one.
        for (int k = 0; k < 8; k++) begin
            din = mk_op(16 + k, 0, 0); din_valid = 1'b1;
            step();
        end
        check("full_count", 32'(count), 8);
        check("full_din_ready", 32'(din_ready), 0);
        din = mk_op(24, 0, 0);
        step();
        check("full_no_accept", 32'(count), 8);
        din_valid = 1'b0; dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check("full_pop_count", 32'(count), 7);
        check("full_pop_ready", 32'(din_ready), 1);
        for (int k = 1; k < 8; k++) begin
            check("full_drain_order", dout, mk_op(16 + k, 0, 0));
            dout_ready = 1'b1;
            step();
        end
        dout_ready = 1'b0;
        check("full_drained", 32'(count), 0);

        // Head blocked on reg 7 while entry 1 is ready.
        dout_ready = 1'b1;
        din = mk_op(32, 7, 0); din_valid = 1'b1;
        step();
        din = mk_op(33, 0, 0);
        step();
        din_valid = 1'b0;
        check("order_count", 32'(count), 2);
        check("order_blocked", 32'(dout_valid), 0);
        step();
        check("order_still_blocked", 32'(count), 2);
        done_flags[5] = 1'b1;
        step();
        done_flags = '0;
        check("order_head_valid", 32'(dout_valid), 1);
        check("order_head_first", dout, mk_op(32, 7, 0));
        step();
        check("order_second", dout, mk_op(33, 0, 0));
        check("order_second_count", 32'(count), 1);
        step();
        dout_ready = 1'b0;
        check("order_drained", 32'(count), 0);

        // Steady push/pop at count 3; pointers wrap several times.
        for (int k = 0; k < 3; k++) begin
            din = mk_op(48 + k, 0, 0); din_valid = 1'b1;
            exp_q.push_back(din);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            din = mk_op(64 + k, 0, 0); din_valid = 1'b1; dout_ready = 1'b1;
            exp_op = exp_q.pop_front();
            check("pp_dout", dout, exp_op);
            exp_q.push_back(din);
            step();
            check("pp_count", 32'(count), 3);
        end
        din_valid = 1'b0;
        while (exp_q.size() > 0) begin
            exp_op = exp_q.pop_front();
            check("pp_tail_order", dout, exp_op);
            step();
        end
        dout_ready = 1'b0;
        check("pp_drained", 32'(count), 0);

        // Flush with five queued and a concurrent push.
        for (int k = 0; k < 5; k++) begin
            din = mk_op(80 + k, 0, 0); din_valid = 1'b1;
            step();
        end
        check("fl_count5", 32'(count), 5);
        flush = 1'b1; din = mk_op(85, 0, 0);
        step();
        flush = 1'b0; din_valid = 1'b0;
        check("fl_count0", 32'(count), 0);
        check("fl_dout_valid", 32'(dout_valid), 0);
        din = mk_op(86, 0, 0); din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("fl_next_op", dout, mk_op(86, 0, 0));
        check("fl_next_count", 32'(count), 1);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;

        // Enqueue-cycle wakeup of srcA=9; srcB=12 arrives later.
        din = mk_op(96, 9, 12); din_valid = 1'b1; done_flags[7] = 1'b1;
        step();
        din_valid = 1'b0; done_flags = '0;
        check("eq_wait_b", 32'(dout_valid), 0);
        done_flags[10] = 1'b1;
        step();
        done_flags = '0;
        check("eq_issue", 32'(dout_valid), 1);
        check("eq_dout", dout, mk_op(96, 9, 12));
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;

        // Sources flagged ready at rename issue immediately.
        din = mk_op(112, 20, 21); din_src_ready = 2'b11; din_valid = 1'b1;
        step();
        din_valid = 1'b0; din_src_ready = 2'b00;
        check("sr_valid", 32'(dout_valid), 1);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check("sr_drained", 32'(count), 0);

        // Reset mid-operation drops queued ops and a same-cycle push.
        din = mk_op(128, 0, 0); din_valid = 1'b1;
        step();
        din = mk_op(129, 0, 0);
        step();
        rst = 1'b1; din = mk_op(130, 0, 0); dout_ready = 1'b1;
        step();
        rst = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_dout_valid", 32'(dout_valid), 0);
        check("rst_din_ready", 32'(din_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count; power of two, at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default `RENAMED_OP_SZ, meaning the renamed memory-op width.
REQ-003 SHALL have port clk, input, 1, meaning the clock.
REQ-004 SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-005 SHALL have port flush, input, 1, meaning discard all queued ops.
REQ-006 SHALL have port din, input, DATA_WIDTH, meaning the renamed memory op from the frontend type sorter.
REQ-007 SHALL have port din_src_ready, input, 2, meaning source A/B already available at rename (bit0=A, bit1=B).
REQ-008 SHALL have port din_valid, input, 1, meaning din is valid.
REQ-009 SHALL have port din_ready, output, 1, meaning the queue accepts din.
REQ-010 SHALL have port done_flags, input, `PHYS_REGS, meaning bit i set when physical reg i+2 completes this cycle.
REQ-011 SHALL have port dout, output, DATA_WIDTH, meaning the head op.
REQ-012 SHALL have port dout_valid, output, 1, meaning the head op is present with both sources ready.
REQ-013 SHALL have port dout_ready, input, 1, meaning the memory unit accepts dout.
REQ-014 SHALL have port count, output, clog2(DEPTH+1), meaning the occupied entry count.

Function
REQ-015 SHALL issue strictly in program order: FIFO, only the head entry may issue.
REQ-016 SHALL store per entry: the op, rdyA and rdyB.
REQ-017 SHALL set rdyX at enqueue if din_src_ready[X]=1, the source reg < 2 (hardwired regs), or done_flags[src-2]=1 in the enqueue cycle.
REQ-018 SHALL, for each valid entry each cycle, set rdyX when done_flags[srcX-2]=1 and srcX >= 2; ready bits never clear while the entry is resident.
REQ-019 SHALL drive dout_valid = (count!=0) & head.rdyA & head.rdyB from registered state only, so a wakeup in cycle N can issue no earlier than cycle N+1.
REQ-020 SHALL drive dout = head op whenever count!=0; dout is don't-care when empty.
REQ-021 SHALL drive din_ready = (count < DEPTH), independent of dout_ready; push into a full queue is not allowed even with a simultaneous pop.
REQ-022 SHALL push when din_valid & din_ready and pop when dout_valid & dout_ready; a simultaneous push and pop leaves count unchanged.
REQ-023 SHALL use head/tail pointers of log2(DEPTH) bits that wrap naturally from DEPTH-1 to 0.
REQ-024 SHALL, when flush=1, set count=0 and head=tail=0 next cycle, ignore any push or pop in that cycle, and drop the entries' ready bits.
REQ-025 SHALL give priority rst > flush > push/pop.
REQ-026 SHALL hold dout stable while dout_valid=1 and dout_ready=0.

Reset
REQ-027 SHALL set on rst: count=0, head=0, tail=0, all ready bits 0; hence dout_valid=0 and din_ready=1 in the following cycle.
REQ-028 SHALL, on rst asserted mid-operation, discard all entries, including a push or pop in that cycle.

Structure
REQ-029 SHALL take `RENAMED_OP_SZ, `PR_ADDR_W, `PHYS_REGS and the source-field offsets SRC_A_LSB and SRC_B_LSB from the shared defines package, not from local constants.
REQ-030 SHALL implement per-operand wakeup (source decode, hardwired check, done_flags match) in one sub-module, operand_wakeup, instantiated twice per entry and once per source on the enqueue path.

Verification
REQ-031 SHALL test: push an op with srcA=5, srcB=0 and din_src_ready=00, then pulse done_flags[3] in cycle N -> dout_valid=1 in cycle N+1 and not before.
REQ-032 SHALL test: push 8 ready ops with no pop -> din_ready=0 and count=8; a 9th din_valid is not accepted; pop one -> din_ready=1 the next cycle.
REQ-033 SHALL test: head waits on reg 7 while entry 1 is ready -> entry 1 does not issue before the head; pulse done_flags[5] -> issue order is head then entry 1.
REQ-034 SHALL test: 20 push/pop pairs at count=3 -> count stays 3 throughout, pointers wrap, output order equals input order.
REQ-035 SHALL test: flush with count=5 and a concurrent push -> count=0 and dout_valid=0 next cycle; the pushed op never appears.
REQ-036 SHALL test: push srcA=9 in the same cycle done_flags[7]=1 -> rdyA is set at enqueue; the op issues next cycle once srcB is ready.
